// File: rtl/de_pipe_reg.sv
// -----------------------------------------------------------------------------
// de_pipe_reg -- decode-to-execute pipeline register.
//
// Captures the decode-stage instruction (valid bit, control fields, operands,
// destination and shift amount) on the rising edge of clk. It presents the
// captured values to the execute stage one cycle later.
//
// Edge priority:
//   1. flush -- load a bubble (every output becomes 0).
//   2. stall -- hold every output.
//   3. load  -- take the d-inputs.
// On a load with dvalid=0, the side-effecting controls (wreg/m2reg/wmem) are
// squashed. The data fields still load.
//
// Optional feature (macro DE_PERF_CNT_EN):
//   When this macro is defined, an ebubbles output is added. It is a saturating
//   32-bit count of the edges that loaded a bubble slot.
//
// Ports:
//   clk, clrn             : rising-edge clock, asynchronous active-low reset
//   stall, flush          : hold / bubble controls
//   dvalid, dwreg, dm2reg, dwmem, daluc, dshift, daluimm,
//   dqa, dqb, dimm, drn, dsa : decode-stage instruction fields
//   e*                    : registered execute-stage copies of the above
//   ebubbles              : bubble counter (DE_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module de_pipe_reg (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic        flush,
    input  logic        dvalid,
    input  logic        dwreg,
    input  logic        dm2reg,
    input  logic        dwmem,
    input  logic [3:0]  daluc,
    input  logic        dshift,
    input  logic        daluimm,
    input  logic [31:0] dqa,
    input  logic [31:0] dqb,
    input  logic [31:0] dimm,
    input  logic [4:0]  drn,
    input  logic [4:0]  dsa,
    output logic        evalid,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic [3:0]  ealuc,
    output logic        eshift,
    output logic        ealuimm,
    output logic [31:0] eqa,
    output logic [31:0] eqb,
    output logic [31:0] eimm,
    output logic [4:0]  ern,
    output logic [4:0]  esa
`ifdef DE_PERF_CNT_EN
    ,
    output logic [31:0] ebubbles
`endif
);

    logic        r_valid;
    logic        r_wreg;
    logic        r_m2reg;
    logic        r_wmem;
    logic [3:0]  r_aluc;
    logic        r_shift;
    logic        r_aluimm;
    logic [31:0] r_qa;
    logic [31:0] r_qb;
    logic [31:0] r_imm;
    logic [4:0]  r_rn;
    logic [4:0]  r_sa;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_valid  <= 1'b0;
            r_wreg   <= 1'b0;
            r_m2reg  <= 1'b0;
            r_wmem   <= 1'b0;
            r_aluc   <= 4'd0;
            r_shift  <= 1'b0;
            r_aluimm <= 1'b0;
            r_qa     <= 32'd0;
            r_qb     <= 32'd0;
            r_imm    <= 32'd0;
            r_rn     <= 5'd0;
            r_sa     <= 5'd0;
        end else if (flush) begin
            // A flush wins over stall. The slot becomes an all-zero bubble.
            r_valid  <= 1'b0;
            r_wreg   <= 1'b0;
            r_m2reg  <= 1'b0;
            r_wmem   <= 1'b0;
            r_aluc   <= 4'd0;
            r_shift  <= 1'b0;
            r_aluimm <= 1'b0;
            r_qa     <= 32'd0;
            r_qb     <= 32'd0;
            r_imm    <= 32'd0;
            r_rn     <= 5'd0;
            r_sa     <= 5'd0;
        end else if (!stall) begin
            r_valid  <= dvalid;
            // An invalid slot must never write the regfile or memory.
            r_wreg   <= dvalid & dwreg;
            r_m2reg  <= dvalid & dm2reg;
            r_wmem   <= dvalid & dwmem;
            r_aluc   <= daluc;
            r_shift  <= dshift;
            r_aluimm <= daluimm;
            r_qa     <= dqa;
            r_qb     <= dqb;
            r_imm    <= dimm;
            r_rn     <= drn;
            r_sa     <= dsa;
        end
    end

    assign evalid  = r_valid;
    assign ewreg   = r_wreg;
    assign em2reg  = r_m2reg;
    assign ewmem   = r_wmem;
    assign ealuc   = r_aluc;
    assign eshift  = r_shift;
    assign ealuimm = r_aluimm;
    assign eqa     = r_qa;
    assign eqb     = r_qb;
    assign eimm    = r_imm;
    assign ern     = r_rn;
    assign esa     = r_sa;

`ifdef DE_PERF_CNT_EN
    logic [31:0] r_bubbles;
    logic        w_bubble_slot;

    // A bubble is loaded by a flush, or by a non-stalled load of an invalid
    // slot. Stall-hold edges load nothing, so they do not count.
    assign w_bubble_slot = flush | (~stall & ~dvalid);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bubbles <= 32'd0;
        end else if (w_bubble_slot && (r_bubbles != 32'hFFFF_FFFF)) begin
            r_bubbles <= r_bubbles + 32'd1;
        end
    end

    assign ebubbles = r_bubbles;
`endif

endmodule

// File: tb/tb_de_pipe_reg.sv
module tb_de_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [3:0]  aluc;
        logic        shift;
        logic        aluimm;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] imm;
        logic [4:0]  rn;
        logic [4:0]  sa;
    } e_t;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        dvalid = 1'b0, dwreg = 1'b0, dm2reg = 1'b0, dwmem = 1'b0;
    logic [3:0]  daluc = '0;
    logic        dshift = 1'b0, daluimm = 1'b0;
    logic [31:0] dqa = '0, dqb = '0, dimm = '0;
    logic [4:0]  drn = '0, dsa = '0;
    logic        evalid, ewreg, em2reg, ewmem, eshift, ealuimm;
    logic [3:0]  ealuc;
    logic [31:0] eqa, eqb, eimm;
    logic [4:0]  ern, esa;
`ifdef DE_PERF_CNT_EN
    logic [31:0] ebubbles;
`endif

    de_pipe_reg dut (
        .clk(clk), .clrn(clrn), .stall(stall), .flush(flush),
        .dvalid(dvalid), .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem),
        .daluc(daluc), .dshift(dshift), .daluimm(daluimm),
        .dqa(dqa), .dqb(dqb), .dimm(dimm), .drn(drn), .dsa(dsa),
        .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealuc(ealuc), .eshift(eshift), .ealuimm(ealuimm),
        .eqa(eqa), .eqb(eqb), .eimm(eimm), .ern(ern), .esa(esa)
`ifdef DE_PERF_CNT_EN
        , .ebubbles(ebubbles)
`endif
    );

    always #5 clk = ~clk;

    int      n_tests = 0;
    int      n_fail  = 0;
    e_t      exp_e   = '0;
    longint  exp_bub = 0;
    e_t      obs_e;

    assign obs_e = {evalid, ewreg, em2reg, ewmem, ealuc, eshift, ealuimm,
                    eqa, eqb, eimm, ern, esa};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one clock edge, stated as the rules of the stage.
    task automatic model_edge();
        e_t n;
        bit bubble;
        bubble = flush || (!stall && !dvalid);
        if (flush) begin
            n = '0;
        end else if (stall) begin
            n = exp_e;
        end else begin
            n.valid  = dvalid;
            n.wreg   = dvalid ? dwreg  : 1'b0;
            n.m2reg  = dvalid ? dm2reg : 1'b0;
            n.wmem   = dvalid ? dwmem  : 1'b0;
            n.aluc   = daluc;   n.shift = dshift; n.aluimm = daluimm;
            n.qa     = dqa;     n.qb    = dqb;    n.imm    = dimm;
            n.rn     = drn;     n.sa    = dsa;
        end
        exp_e = n;
        if (bubble && exp_bub < 64'hFFFF_FFFF) exp_bub++;
    endtask

    task automatic check_all(input string tag);
        chk(tag, 128'(obs_e), 128'(exp_e));
`ifdef DE_PERF_CNT_EN
        chk({tag, "_bub"}, 128'(ebubbles), 128'(exp_bub[31:0]));
`endif
    endtask

    // One clock edge: the model samples the inputs at the edge, and outputs are checked 1ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_d();
        dvalid = ($urandom_range(0, 9) < 7); dwreg = 1'($urandom); dm2reg = 1'($urandom);
        dwmem = 1'($urandom); daluc = 4'($urandom); dshift = 1'($urandom);
        daluimm = 1'($urandom); dqa = $urandom; dqb = $urandom; dimm = $urandom;
        drn = 5'($urandom); dsa = 5'($urandom);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset(input string tag);
        #2 clrn = 1'b0;
        #1;
        exp_e = '0; exp_bub = 0;
        check_all(tag);
        #1 clrn = 1'b1;
    endtask

    e_t held;

    initial begin
        // Reset is held at time 0; outputs must be zero with no clock edge required.
        #1;
        check_all("por");
        #3 clrn = 1'b1;

        // Load something, then assert reset mid-cycle.
        rand_d(); dvalid = 1'b1;
        cycle("pre_load");
        mid_reset("async_rst");

        // Reset, then load.
        rand_d(); dvalid = 1'b1; dqa = 32'h1234_5678; drn = 5'd9; dwreg = 1'b1;
        cycle("load");
        chk("load_eqa", 128'(eqa), 128'(32'h1234_5678));
        chk("load_ern", 128'(ern), 128'(5'd9));
        chk("load_ewreg", 128'(ewreg), 128'(1'b1));
        chk("load_evalid", 128'(evalid), 128'(1'b1));

        // Stall for 3 cycles while the d-inputs change.
        held = obs_e;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            cycle("stall");
            chk("stall_hold", 128'(obs_e), 128'(held));
        end
        stall = 1'b0; rand_d(); dvalid = 1'b1;
        cycle("stall_rel");
        chk("rel_eqa", 128'(eqa), 128'(dqa));

        // Flush combined with stall.
        flush = 1'b1; stall = 1'b1; dvalid = 1'b1; dwmem = 1'b1; dqb = 32'hDEAD_BEEF;
        cycle("flush_stall");
        chk("fs_ewmem", 128'(ewmem), 128'(1'b0));
        chk("fs_eqb", 128'(eqb), 128'(32'd0));
        chk("fs_evalid", 128'(evalid), 128'(1'b0));
        flush = 1'b0; stall = 1'b0;

        // Invalid slot.
        rand_d(); dvalid = 1'b0; dwreg = 1'b1; dwmem = 1'b1; daluc = 4'hA;
        cycle("invalid");
        chk("inv_ewreg", 128'(ewreg), 128'(1'b0));
        chk("inv_ewmem", 128'(ewmem), 128'(1'b0));
        chk("inv_ealuc", 128'(ealuc), 128'(4'hA));
        chk("inv_evalid", 128'(evalid), 128'(1'b0));

`ifdef DE_PERF_CNT_EN
        // Counter: 2 flushes, 1 invalid load and 4 stalls give 3 bubbles.
        mid_reset("cnt_rst");
        rand_d(); flush = 1'b1;
        cycle("cnt_f1"); cycle("cnt_f2");
        flush = 1'b0; dvalid = 1'b0;
        cycle("cnt_inv");
        stall = 1'b1;
        for (int i = 0; i < 4; i++) cycle("cnt_stall");
        stall = 1'b0;
        chk("cnt_three", 128'(ebubbles), 128'(32'd3));
        // Saturation test: preload the counter, then add 3 bubbles.
        force dut.r_bubbles = 32'hFFFF_FFFE;
        #1 release dut.r_bubbles;
        exp_bub = 64'hFFFF_FFFE;
        dvalid = 1'b0;
        for (int i = 0; i < 3; i++) cycle("cnt_sat");
        chk("cnt_sat_val", 128'(ebubbles), 128'(32'hFFFF_FFFF));
        mid_reset("cnt_rst2");
`endif

        // Randomised traffic, with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            rand_d();
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            cycle("rand");
            if ($urandom_range(0, 49) == 0) mid_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
